// File: rtl/rstseq_pkg.sv
// Shared types and reset values for the staged reset sequencer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_PHYWAIT = 2'd1,
    S_MAC     = 2'd2,
    S_RUN     = 2'd3
  } rstseq_state_t;

  localparam logic PHY_RST_N_RST    = 1'b0;
  localparam logic MAC_RST_RST      = 1'b1;
  localparam logic USER_RST_RST     = 1'b1;
  localparam logic SEQ_DONE_RST     = 1'b0;
  localparam logic SOFT_RST_ACK_RST = 1'b0;
  localparam logic WDT_FIRED_RST    = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rstseq_dncnt.sv
// Loadable down-counter that saturates at zero.
module rstseq_dncnt
  import rstseq_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered PHY -> MAC -> user reset release with soft re-sequence.
// Optional heartbeat watchdog enabled by defining RSTSEQ_WDT_EN.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int PHY_RST_CYC   = 250000,
  parameter int PHY_WAIT_CYC  = 125000,
  parameter int STAGE_GAP_CYC = 16,
  parameter int WDT_CYC       = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic soft_rst_req,
  output logic soft_rst_ack,
  output logic phy_rst_N,
  output logic mac_rst,
  output logic user_rst,
`ifdef RSTSEQ_WDT_EN
  input  logic wdt_kick,
  output logic wdt_fired,
`endif
  output logic seq_done
);

  localparam int STG_MAX =
    imax(imax(PHY_RST_CYC, PHY_WAIT_CYC), STAGE_GAP_CYC);
`ifdef RSTSEQ_WDT_EN
  localparam int CNT_MAX = imax(STG_MAX, WDT_CYC);
`else
  localparam int CNT_MAX = STG_MAX;
`endif
  localparam int CW = cnt_w(CNT_MAX);

  localparam logic [CW-1:0] HOLD_LD = CW'(PHY_RST_CYC - 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(PHY_WAIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP_CYC - 1);

  if (PHY_RST_CYC < 1 || PHY_WAIT_CYC < 1 ||
      STAGE_GAP_CYC < 1 || WDT_CYC < 2) begin : g_bad_cfg
    $error("reset_sequencer: cycle parameter out of range");
  end

  rstseq_state_t state, state_nx;
  logic          load;
  logic [CW-1:0] load_val;
  logic          zero;
  logic          ack_nx;
  logic          fire;

  rstseq_dncnt #(
    .W       (CW),
    .RST_VAL (HOLD_LD)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

`ifdef RSTSEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYC - 1);

  logic [CW-1:0] wdt_cnt;
  logic          wdt_exp;

  assign wdt_exp = (wdt_cnt == WDT_LAST) && !wdt_kick;
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    ack_nx   = 1'b0;
    fire     = 1'b0;
    unique case (state)
      S_HOLD: if (zero) begin
        state_nx = S_PHYWAIT;
        load     = 1'b1;
        load_val = WAIT_LD;
      end
      S_PHYWAIT: if (zero) begin
        state_nx = S_MAC;
        load     = 1'b1;
        load_val = GAP_LD;
      end
      S_MAC: if (zero) begin
        state_nx = S_RUN;
      end
      S_RUN: begin
        // soft request outranks a coincident watchdog expiry
        if (soft_rst_req) begin
          state_nx = S_HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
          ack_nx   = 1'b1;
        end
`ifdef RSTSEQ_WDT_EN
        else if (wdt_exp) begin
          state_nx = S_HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
          fire     = 1'b1;
        end
`endif
      end
      default: state_nx = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HOLD;
      phy_rst_N    <= PHY_RST_N_RST;
      mac_rst      <= MAC_RST_RST;
      user_rst     <= USER_RST_RST;
      seq_done     <= SEQ_DONE_RST;
      soft_rst_ack <= SOFT_RST_ACK_RST;
    end else begin
      state        <= state_nx;
      phy_rst_N    <= (state_nx != S_HOLD);
      mac_rst      <= (state_nx == S_HOLD) ||
                      (state_nx == S_PHYWAIT);
      user_rst     <= (state_nx != S_RUN);
      seq_done     <= (state_nx == S_RUN);
      soft_rst_ack <= ack_nx;
    end
  end

`ifdef RSTSEQ_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt   <= '0;
      wdt_fired <= WDT_FIRED_RST;
    end else begin
      if (state == S_RUN && state_nx == S_RUN && !wdt_kick)
        wdt_cnt <= wdt_cnt + 1'b1;
      else
        wdt_cnt <= '0;
      if (fire)
        wdt_fired <= 1'b1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a stage-time model.
// Define RSTSEQ_WDT_EN to also exercise the watchdog.
module tb_reset_sequencer;

  localparam int P  = 8;
  localparam int W  = 4;
  localparam int G  = 2;
  localparam int S  = P + W + G;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst;
  logic soft_rst_req;
  logic soft_rst_ack;
  logic phy_rst_N;
  logic mac_rst;
  logic user_rst;
  logic seq_done;
`ifdef RSTSEQ_WDT_EN
  logic wdt_kick;
  logic wdt_fired;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .PHY_RST_CYC   (P),
    .PHY_WAIT_CYC  (W),
    .STAGE_GAP_CYC (G),
    .WDT_CYC       (WD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .phy_rst_N    (phy_rst_N),
    .mac_rst      (mac_rst),
    .user_rst     (user_rst),
`ifdef RSTSEQ_WDT_EN
    .wdt_kick     (wdt_kick),
    .wdt_fired    (wdt_fired),
`endif
    .seq_done     (seq_done)
  );

  // model: t = edges since the sequence (re)started
  int t = 0;
  int n = 0;
  int run_entry = 0;
  int last_kick = -1000;
  int since = 0;
  bit was_run;
  bit m_ack = 1'b0;
  bit m_fired = 1'b0;

  always @(posedge clk) begin
    n++;
    was_run = (t >= S);
    if (rst) begin
      t = 0;
      m_ack = 1'b0;
      m_fired = 1'b0;
    end else begin
      m_ack = 1'b0;
      since = n - ((last_kick > run_entry) ? last_kick : run_entry);
      if (was_run && soft_rst_req) begin
        t = 0;
        m_ack = 1'b1;
      end
`ifdef RSTSEQ_WDT_EN
      else if (was_run && !wdt_kick && since >= WD) begin
        t = 0;
        m_fired = 1'b1;
      end
`endif
      else if (t < S) begin
        t++;
        if (t == S) run_entry = n;
      end
`ifdef RSTSEQ_WDT_EN
      if (was_run && wdt_kick) last_kick = n;
`endif
    end
  end

  always @(negedge clk) begin
    logic e_phy, e_mac, e_user, e_done, bad;
    if (n > 0) begin
      e_phy  = (t >= P);
      e_mac  = (t < P + W);
      e_user = (t < S);
      e_done = (t >= S);
      bad = (phy_rst_N !== e_phy) || (mac_rst !== e_mac) ||
            (user_rst !== e_user) || (seq_done !== e_done) ||
            (soft_rst_ack !== m_ack);
`ifdef RSTSEQ_WDT_EN
      bad = bad || (wdt_fired !== m_fired);
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL model edge %0d: got phyN=%b mac=%b user=%b done=%b ack=%b, want %b %b %b %b %b",
                 n, phy_rst_N, mac_rst, user_rst, seq_done, soft_rst_ack,
                 e_phy, e_mac, e_user, e_done, m_ack);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic seq_tail(input string tag);
    for (int i = 2; i <= S; i++) begin
      @(negedge clk);
      if (i == P - 1) chk({tag, "_phy_lo"}, phy_rst_N, 0);
      if (i == P)     chk({tag, "_phy_hi"}, phy_rst_N, 1);
      if (i == S - 1) chk({tag, "_done_lo"}, seq_done, 0);
      if (i == S)     chk({tag, "_done_hi"}, seq_done, 1);
    end
  endtask

  initial begin
    int waited;
    bit got;
    rst = 1'b1;
    soft_rst_req = 1'b0;
`ifdef RSTSEQ_WDT_EN
    wdt_kick = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_phyN", phy_rst_N, 0);
    chk("rst_mac", mac_rst, 1);
    chk("rst_user", user_rst, 1);
    chk("rst_done", seq_done, 0);
    chk("rst_ack", soft_rst_ack, 0);

    // power-up
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 7)  chk("pu_phy7", phy_rst_N, 0);
      if (i == 8)  chk("pu_phy8", phy_rst_N, 1);
      if (i == 11) chk("pu_mac11", mac_rst, 1);
      if (i == 12) chk("pu_mac12", mac_rst, 0);
      if (i == 13) chk("pu_user13", user_rst, 1);
      if (i == 14) chk("pu_user14", user_rst, 0);
      if (i == 14) chk("pu_done14", seq_done, 1);
    end

    // soft reset in run
    soft_rst_req = 1'b1;
    @(negedge clk);
    chk("soft_ack", soft_rst_ack, 1);
    chk("soft_phy", phy_rst_N, 0);
    chk("soft_done", seq_done, 0);
    soft_rst_req = 1'b0;
    @(negedge clk);
    chk("soft_ack_1cyc", soft_rst_ack, 0);
    seq_tail("soft");

    // soft request while in phy wait
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("pw_phy", phy_rst_N, 1);
    chk("pw_mac", mac_rst, 1);
    soft_rst_req = 1'b1;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 30) begin
      @(negedge clk);
      waited++;
      if (soft_rst_ack) got = 1'b1;
    end
    chk("pw_ack_seen", got, 1);
    chk("pw_ack_lat", waited, 7);
    soft_rst_req = 1'b0;
    @(negedge clk);
    chk("pw_ack_1cyc", soft_rst_ack, 0);
    seq_tail("pw");

    // rst pulse while in mac stage
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_mac", mac_rst, 0);
    chk("mid_user", user_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_phy", phy_rst_N, 0);
    chk("mid_rst_mac", mac_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    seq_tail("mid");

`ifdef RSTSEQ_WDT_EN
    // regular kicks keep it running
    for (int j = 0; j < 5; j++) begin
      wdt_kick = 1'b1;
      @(negedge clk);
      wdt_kick = 1'b0;
      repeat (9) @(negedge clk);
    end
    chk("wdt_kicked_fired", wdt_fired, 0);
    chk("wdt_kicked_done", seq_done, 1);
    for (int i = 10; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) chk("wdt_15_done", seq_done, 1);
      if (i == 16) begin
        chk("wdt_16_done", seq_done, 0);
        chk("wdt_16_fired", wdt_fired, 1);
        chk("wdt_16_ack", soft_rst_ack, 0);
      end
    end
    repeat (S) @(negedge clk);
    chk("wdt_sticky", wdt_fired, 1);

    // soft request coincident with expiry
    rst = 1'b1;
    @(negedge clk);
    chk("wdt_rst_clr", wdt_fired, 0);
    rst = 1'b0;
    repeat (S + WD - 1) @(negedge clk);
    soft_rst_req = 1'b1;
    @(negedge clk);
    chk("both_ack", soft_rst_ack, 1);
    chk("both_fired", wdt_fired, 0);
    chk("both_done", seq_done, 0);
    soft_rst_req = 1'b0;
    repeat (4) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
